pipeline_sequencer: RTL and testbench
=====================================

# pipeline_sequencer

Central stall/flush controller for the 5-stage pipeline. It turns hazard-detection bubble requests, execute-stage branch redirects and data-memory wait handshakes into per-stage register enables and flush (NOP-insert) strobes. It also owns the run/drain/halt lifecycle of the core and keeps saturating stall and flush counters. It sits between `hazard_detection`, the execute and memory stages, and the FD/DX/XM/MW pipeline registers plus the PC.

## Interface
- `CNT_W`, 16: width of the performance counters.
- `MEM_TIMEOUT`, 64: number of consecutive memory-wait cycles that forces the ERROR state. Legal range is 2..2^CNT_W-1.
- `DRAIN_CYCLES`, 3: cycles spent in DRAIN after a halt, enough to retire DX, XM and MW.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle pulse; leaves IDLE or HALTED.
- `bubble`  in  1  load/store-use bubble request from `hazard_detection`.
- `branch_taken_x`  in  1  the execute stage redirects the PC this cycle.
- `halt_req_d`  in  1  a halt/done instruction is in decode.
- `dmem_req_m`  in  1  the memory stage holds a load or store.
- `dmem_ack`  in  1  data memory completes the access this cycle.
- `en_pc`, `en_fd`, `en_dx`, `en_xm`, `en_mw`  out  1 each  register load enables.
- `flush_fd`, `flush_dx`  out  1 each  load a NOP into FD or DX (only meaningful with the matching enable high).
- `running`  out  1  high in RUN and MEM_WAIT.
- `error`  out  1  high in ERROR.
- `state_o`  out  3  IDLE=0, RUN=1, MEM_WAIT=2, DRAIN=3, HALTED=4, ERROR=5.
- `stall_cnt`  out  CNT_W  count of stall cycles.
- `flush_cnt`  out  CNT_W  count of branch flushes.

## Operation
Outputs are Mealy: they are derived combinationally from the registered state and the current inputs. The registered items are the state, `wait_cnt`, `drain_cnt` and both counters.

**Idle-type states.** In IDLE, HALTED and ERROR, all enables and flushes are 0.
- IDLE or HALTED with `start`=1 → RUN. Both counters clear on the same edge.
- ERROR is sticky until `reset`.

**RUN.** Conditions are evaluated in this priority order; the first match wins.
1. Memory stall, `dmem_req_m && !dmem_ack`: all five enables 0 and no flushes. Next state MEM_WAIT with `wait_cnt`=1. `stall_cnt` increments.
2. Branch, `branch_taken_x`: all enables 1, `flush_fd`=1 and `flush_dx`=1. `flush_cnt` increments. Any `bubble` or `halt_req_d` in the same cycle is ignored, because that instruction is squashed.
3. Halt, `halt_req_d`: `en_pc`=0, `en_fd`=0, `en_dx`=1 with `flush_dx`=1, `en_xm`=1, `en_mw`=1. Next state DRAIN with `drain_cnt`=1.
4. Bubble: `en_pc`=0, `en_fd`=0, `en_dx`=1 with `flush_dx`=1, `en_xm`=1, `en_mw`=1. `stall_cnt` increments.
5. Otherwise: all enables 1 and no flushes.

**MEM_WAIT.**
- `dmem_ack`=0: all enables 0. `wait_cnt` and `stall_cnt` increment. When `wait_cnt` reaches MEM_TIMEOUT, next state is ERROR.
- `dmem_ack`=1: outputs follow RUN rules 2 through 5 using the current inputs. The next state is whatever those rules select, otherwise RUN. `wait_cnt` clears.

**DRAIN.**
- `en_pc`=0 and `en_fd`=0. `en_dx`, `en_xm` and `en_mw` are 1, with `flush_dx`=1.
- A `dmem_req_m && !dmem_ack` cycle freezes all enables and does not advance `drain_cnt`.
- When `drain_cnt` reaches DRAIN_CYCLES, next state is HALTED.
- Other inputs are ignored.

**Counters.** `stall_cnt` and `flush_cnt` saturate at 2^CNT_W−1 and never wrap.

## Timing
- `reset` asserted, asynchronously: state goes to IDLE, and `wait_cnt`, `drain_cnt`, `stall_cnt` and `flush_cnt` all go to 0. As a result, all enables and flushes are 0, `running`=0, `error`=0 and `state_o`=0.
- Reset asserted mid-stall or mid-drain aborts immediately. No partial drain is performed.
- Enables respond to the inputs with zero-cycle latency, in the same cycle.
- State and counter updates are visible one cycle later.
- Memory handshake: a request held for N cycles with `dmem_ack` arriving on cycle N freezes the pipeline for N−1 cycles. Enables rise in the `dmem_ack` cycle.
- ERROR is entered on the edge ending wait cycle MEM_TIMEOUT, provided no `dmem_ack` arrived in that cycle. `dmem_ack` in that same cycle takes precedence and returns to RUN.
- Branch + bubble in the same cycle: the branch wins, and no PC stall occurs.
- Memory stall + branch in the same cycle: the branch is held off. Its inputs are re-evaluated in the `dmem_ack` cycle.

## Test plan
- **Reset values.** Assert `reset`, then pulse `start` → `state_o`=1, all enables 1, both counters 0.
- **Bubble.** In RUN, `bubble`=1 for 1 cycle → `en_pc`=0, `en_fd`=0, `flush_dx`=1, `en_xm`=1 that cycle; `stall_cnt`=1 on the next cycle.
- **Memory wait.** `dmem_req_m`=1 with `dmem_ack` arriving on the 4th cycle → enables 0 for 3 cycles, `state_o`=2 for cycles 2–4, all enables 1 in cycle 4, `stall_cnt`=3.
- **Branch priority.** `branch_taken_x`=1, `bubble`=1 and `halt_req_d`=1 in the same cycle → all enables 1, `flush_fd`=1, `flush_dx`=1, `flush_cnt`=1, state stays RUN.
- **Halt.** `halt_req_d`=1 → DRAIN for 3 cycles with `en_pc`=0, then `state_o`=4 and `running`=0; a subsequent `start` → RUN.
- **Timeout.** With MEM_TIMEOUT=4, hold `dmem_req_m`=1 with `dmem_ack`=0 → `error`=1 after 4 wait cycles and it stays there; `start` has no effect; only `reset` clears it. Also check saturation: with CNT_W=4, 20 bubbles → `stall_cnt`=15.

Source files
------------

// File: rtl/pipeline_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : pipeline_sequencer_if                                       |
// | Brief  : Control bundle between the pipeline sequencer and the       |
// |          hazard, execute, memory and pipeline-register logic.        |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
interface pipeline_sequencer_if #(
  parameter int CNT_W = 16
);
  // Requests into the sequencer
  logic             start;
  logic             bubble;
  logic             branch_taken_x;
  logic             halt_req_d;
  logic             dmem_req_m;
  logic             dmem_ack;

  // Enables, flushes and status out of the sequencer
  logic             en_pc;
  logic             en_fd;
  logic             en_dx;
  logic             en_xm;
  logic             en_mw;
  logic             flush_fd;
  logic             flush_dx;
  logic             running;
  logic             error;
  logic [2:0]       state_o;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Side that raises the requests and consumes the enables
  modport master (
    output start, bubble, branch_taken_x, halt_req_d, dmem_req_m, dmem_ack,
    input  en_pc, en_fd, en_dx, en_xm, en_mw, flush_fd, flush_dx,
    input  running, error, state_o, stall_cnt, flush_cnt
  );

  // The sequencer itself
  modport slave (
    input  start, bubble, branch_taken_x, halt_req_d, dmem_req_m, dmem_ack,
    output en_pc, en_fd, en_dx, en_xm, en_mw, flush_fd, flush_dx,
    output running, error, state_o, stall_cnt, flush_cnt
  );
endinterface
`default_nettype wire

// File: rtl/pipeline_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : pipeline_sequencer                                          |
// | Brief  : Stall/flush controller for the 5-stage pipeline. Turns      |
// |          bubble, branch and memory-wait events into per-stage        |
// |          enables and NOP strobes, runs the run/drain/halt lifecycle  |
// |          and keeps saturating stall and flush counters.              |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module pipeline_sequencer #(
  parameter int CNT_W        = 16,
  parameter int MEM_TIMEOUT  = 64,
  parameter int DRAIN_CYCLES = 3
) (
  input  wire logic            clk,
  input  wire logic            reset,
  pipeline_sequencer_if.slave  bus
);

  // drain_cnt has to hold DRAIN_CYCLES itself
  localparam int DRAIN_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

  localparam logic [CNT_W-1:0]   C_TIMEOUT    = CNT_W'(MEM_TIMEOUT);
  localparam logic [DRAIN_W-1:0] C_DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RUN      = 3'd1,
    S_MEM_WAIT = 3'd2,
    S_DRAIN    = 3'd3,
    S_HALTED   = 3'd4,
    S_ERROR    = 3'd5
  } state_t;

  state_t             state_q,     state_d;
  logic [CNT_W-1:0]   wait_cnt_q,  wait_cnt_d;
  logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

  logic en_pc, en_fd, en_dx, en_xm, en_mw, flush_fd, flush_dx;
  logic mem_stall;

  // Counters stick at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign mem_stall = bus.dmem_req_m && !bus.dmem_ack;

  // Mealy decode: enables/flushes and next-state from registered state plus live inputs
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    drain_cnt_d = drain_cnt_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    en_pc       = 1'b0;
    en_fd       = 1'b0;
    en_dx       = 1'b0;
    en_xm       = 1'b0;
    en_mw       = 1'b0;
    flush_fd    = 1'b0;
    flush_dx    = 1'b0;

    case (state_q)
      S_IDLE, S_HALTED: begin
        if (bus.start) begin
          state_d     = S_RUN;
          stall_cnt_d = '0;
          flush_cnt_d = '0;
        end
      end

      S_RUN, S_MEM_WAIT: begin
        if (state_q == S_RUN && mem_stall) begin
          // New memory stall freezes everything; any branch is re-seen on ack
          state_d     = S_MEM_WAIT;
          wait_cnt_d  = CNT_W'(1);
          stall_cnt_d = sat_inc(stall_cnt_q);
        end else if (state_q == S_MEM_WAIT && !bus.dmem_ack) begin
          wait_cnt_d  = wait_cnt_q + CNT_W'(1);
          stall_cnt_d = sat_inc(stall_cnt_q);
          if (wait_cnt_d == C_TIMEOUT) begin
            state_d = S_ERROR;
          end
        end else begin
          // Normal issue (or the ack cycle of a wait): branch > halt > bubble
          state_d    = S_RUN;
          wait_cnt_d = '0;
          if (bus.branch_taken_x) begin
            // Squashes the decode instruction, so its halt/bubble is dropped
            {en_pc, en_fd, en_dx, en_xm, en_mw} = 5'b11111;
            flush_fd    = 1'b1;
            flush_dx    = 1'b1;
            flush_cnt_d = sat_inc(flush_cnt_q);
          end else if (bus.halt_req_d) begin
            {en_pc, en_fd, en_dx, en_xm, en_mw} = 5'b00111;
            flush_dx    = 1'b1;
            state_d     = S_DRAIN;
            drain_cnt_d = DRAIN_W'(1);
          end else if (bus.bubble) begin
            {en_pc, en_fd, en_dx, en_xm, en_mw} = 5'b00111;
            flush_dx    = 1'b1;
            stall_cnt_d = sat_inc(stall_cnt_q);
          end else begin
            {en_pc, en_fd, en_dx, en_xm, en_mw} = 5'b11111;
          end
        end
      end

      S_DRAIN: begin
        // Retire the back stages with NOPs behind; a memory wait pauses the drain
        if (!mem_stall) begin
          {en_pc, en_fd, en_dx, en_xm, en_mw} = 5'b00111;
          flush_dx = 1'b1;
          if (drain_cnt_q == C_DRAIN_LAST) begin
            state_d     = S_HALTED;
            drain_cnt_d = '0;
          end else begin
            drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
          end
        end
      end

      default: begin
        // ERROR (and unreachable codes) hold until reset
      end
    endcase
  end

  // State and counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wait_cnt_q  <= '0;
      drain_cnt_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.en_pc     = en_pc;
  assign bus.en_fd     = en_fd;
  assign bus.en_dx     = en_dx;
  assign bus.en_xm     = en_xm;
  assign bus.en_mw     = en_mw;
  assign bus.flush_fd  = flush_fd;
  assign bus.flush_dx  = flush_dx;
  assign bus.running   = (state_q == S_RUN) || (state_q == S_MEM_WAIT);
  assign bus.error     = (state_q == S_ERROR);
  assign bus.state_o   = state_q;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_pipeline_sequencer                                       |
// | Brief  : Scenario bench for pipeline_sequencer (CNT_W=4,             |
// |          MEM_TIMEOUT=4, DRAIN_CYCLES=3).                             |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_pipeline_sequencer;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  pipeline_sequencer_if #(.CNT_W(4)) bus ();

  pipeline_sequencer #(
    .CNT_W        (4),
    .MEM_TIMEOUT  (4),
    .DRAIN_CYCLES (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ctl = {en_pc,en_fd,en_dx,en_xm,en_mw, flush_fd,flush_dx, running, error, state_o}
  localparam logic [11:0] C_IDLE    = 12'b00000_00_0_0_000;
  localparam logic [11:0] C_RUN_ALL = 12'b11111_00_1_0_001;
  localparam logic [11:0] C_RUN_FRZ = 12'b00000_00_1_0_001;
  localparam logic [11:0] C_RUN_BUB = 12'b00111_01_1_0_001;
  localparam logic [11:0] C_RUN_BR  = 12'b11111_11_1_0_001;
  localparam logic [11:0] C_MW_FRZ  = 12'b00000_00_1_0_010;
  localparam logic [11:0] C_MW_ALL  = 12'b11111_00_1_0_010;
  localparam logic [11:0] C_MW_BR   = 12'b11111_11_1_0_010;
  localparam logic [11:0] C_MW_BUB  = 12'b00111_01_1_0_010;
  localparam logic [11:0] C_DRN     = 12'b00111_01_0_0_011;
  localparam logic [11:0] C_DRN_FRZ = 12'b00000_00_0_0_011;
  localparam logic [11:0] C_HLT     = 12'b00000_00_0_0_100;
  localparam logic [11:0] C_ERR     = 12'b00000_00_0_1_101;

  // in = {start, bubble, branch_taken_x, halt_req_d, dmem_req_m, dmem_ack}
  localparam logic [5:0] I_NONE  = 6'b000000;
  localparam logic [5:0] I_START = 6'b100000;
  localparam logic [5:0] I_BUB   = 6'b010000;
  localparam logic [5:0] I_BR    = 6'b001000;
  localparam logic [5:0] I_HALT  = 6'b000100;
  localparam logic [5:0] I_REQ   = 6'b000010;
  localparam logic [5:0] I_ACK   = 6'b000011;

  typedef struct packed {
    logic [11:0] ctl;
    logic [3:0]  stall;
    logic [3:0]  flush;
  } exp_t;

  typedef struct packed {
    logic [5:0]  in;
    logic [11:0] ctl;
    logic [3:0]  stall;
    logic [3:0]  flush;
  } stim_t;

  exp_t sb_q[$];
  exp_t got, want;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic apply(input logic [5:0] v);
    {bus.start, bus.bubble, bus.branch_taken_x, bus.halt_req_d, bus.dmem_req_m, bus.dmem_ack} = v;
  endtask

  function automatic exp_t dut_obs();
    return {bus.en_pc, bus.en_fd, bus.en_dx, bus.en_xm, bus.en_mw, bus.flush_fd, bus.flush_dx,
            bus.running, bus.error, bus.state_o, bus.stall_cnt, bus.flush_cnt};
  endfunction

  // Reset, then one start pulse: leaves the DUT in RUN with cleared counters at posedge+1
  task automatic restart();
    apply(I_NONE);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    apply(I_START);
    @(posedge clk); #1;
    apply(I_NONE);
  endtask

  task automatic test_reset();
    stim_t tbl[4];
    tbl = '{ {I_NONE,  C_IDLE,    4'd0, 4'd0},
             {I_START, C_IDLE,    4'd0, 4'd0},
             {I_NONE,  C_RUN_ALL, 4'd0, 4'd0},
             {I_NONE,  C_RUN_ALL, 4'd0, 4'd0} };
    apply(I_NONE);
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    foreach (tbl[i]) begin
      apply(tbl[i].in);
      sb_q.push_back({tbl[i].ctl, tbl[i].stall, tbl[i].flush});
      @(negedge clk);
      got = dut_obs(); want = sb_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL reset[%0d]: got ctl=%b stall=%0d flush=%0d, expected ctl=%b stall=%0d flush=%0d",
                 i, got.ctl, got.stall, got.flush, want.ctl, want.stall, want.flush);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_bubble();
    stim_t tbl[5];
    tbl = '{ {I_BUB,  C_RUN_BUB, 4'd0, 4'd0},
             {I_NONE, C_RUN_ALL, 4'd1, 4'd0},
             {I_BUB,  C_RUN_BUB, 4'd1, 4'd0},
             {I_BUB,  C_RUN_BUB, 4'd2, 4'd0},
             {I_NONE, C_RUN_ALL, 4'd3, 4'd0} };
    restart();
    foreach (tbl[i]) begin
      apply(tbl[i].in);
      sb_q.push_back({tbl[i].ctl, tbl[i].stall, tbl[i].flush});
      @(negedge clk);
      got = dut_obs(); want = sb_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL bubble[%0d]: got ctl=%b stall=%0d flush=%0d, expected ctl=%b stall=%0d flush=%0d",
                 i, got.ctl, got.stall, got.flush, want.ctl, want.stall, want.flush);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mem_wait();
    stim_t tbl[7];
    tbl = '{ {I_REQ,  C_RUN_FRZ, 4'd0, 4'd0},
             {I_REQ,  C_MW_FRZ,  4'd1, 4'd0},
             {I_REQ,  C_MW_FRZ,  4'd2, 4'd0},
             {I_ACK,  C_MW_ALL,  4'd3, 4'd0},
             {I_NONE, C_RUN_ALL, 4'd3, 4'd0},
             {I_ACK,  C_RUN_ALL, 4'd3, 4'd0},
             {I_NONE, C_RUN_ALL, 4'd3, 4'd0} };
    restart();
    foreach (tbl[i]) begin
      apply(tbl[i].in);
      sb_q.push_back({tbl[i].ctl, tbl[i].stall, tbl[i].flush});
      @(negedge clk);
      got = dut_obs(); want = sb_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL mem_wait[%0d]: got ctl=%b stall=%0d flush=%0d, expected ctl=%b stall=%0d flush=%0d",
                 i, got.ctl, got.stall, got.flush, want.ctl, want.stall, want.flush);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch_priority();
    stim_t tbl[8];
    tbl = '{ {I_BR | I_BUB | I_HALT, C_RUN_BR,  4'd0, 4'd0},
             {I_NONE,                C_RUN_ALL, 4'd0, 4'd1},
             {I_BR,                  C_RUN_BR,  4'd0, 4'd1},
             {I_BR,                  C_RUN_BR,  4'd0, 4'd2},
             {I_NONE,                C_RUN_ALL, 4'd0, 4'd3},
             {I_REQ | I_BR,          C_RUN_FRZ, 4'd0, 4'd3},
             {I_ACK | I_BR,          C_MW_BR,   4'd1, 4'd3},
             {I_NONE,                C_RUN_ALL, 4'd1, 4'd4} };
    restart();
    foreach (tbl[i]) begin
      apply(tbl[i].in);
      sb_q.push_back({tbl[i].ctl, tbl[i].stall, tbl[i].flush});
      @(negedge clk);
      got = dut_obs(); want = sb_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL branch[%0d]: got ctl=%b stall=%0d flush=%0d, expected ctl=%b stall=%0d flush=%0d",
                 i, got.ctl, got.stall, got.flush, want.ctl, want.stall, want.flush);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_halt();
    stim_t tbl[10];
    tbl = '{ {I_BUB,                  C_RUN_BUB, 4'd0, 4'd0},
             {I_HALT,                 C_RUN_BUB, 4'd1, 4'd0},
             {I_NONE,                 C_DRN,     4'd1, 4'd0},
             {I_REQ,                  C_DRN_FRZ, 4'd1, 4'd0},
             {I_NONE,                 C_DRN,     4'd1, 4'd0},
             {I_START | I_BUB | I_BR, C_DRN,     4'd1, 4'd0},
             {I_NONE,                 C_HLT,     4'd1, 4'd0},
             {I_NONE,                 C_HLT,     4'd1, 4'd0},
             {I_START,                C_HLT,     4'd1, 4'd0},
             {I_NONE,                 C_RUN_ALL, 4'd0, 4'd0} };
    restart();
    foreach (tbl[i]) begin
      apply(tbl[i].in);
      sb_q.push_back({tbl[i].ctl, tbl[i].stall, tbl[i].flush});
      @(negedge clk);
      got = dut_obs(); want = sb_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL halt[%0d]: got ctl=%b stall=%0d flush=%0d, expected ctl=%b stall=%0d flush=%0d",
                 i, got.ctl, got.stall, got.flush, want.ctl, want.stall, want.flush);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    stim_t tbl[5];
    tbl = '{ {I_REQ,          C_RUN_FRZ, 4'd0, 4'd0},
             {I_ACK | I_BUB,  C_MW_BUB,  4'd1, 4'd0},
             {I_REQ,          C_RUN_FRZ, 4'd2, 4'd0},
             {I_ACK | I_HALT, C_MW_BUB,  4'd3, 4'd0},
             {I_NONE,         C_DRN,     4'd3, 4'd0} };
    restart();
    foreach (tbl[i]) begin
      apply(tbl[i].in);
      sb_q.push_back({tbl[i].ctl, tbl[i].stall, tbl[i].flush});
      @(negedge clk);
      got = dut_obs(); want = sb_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL back_to_back[%0d]: got ctl=%b stall=%0d flush=%0d, expected ctl=%b stall=%0d flush=%0d",
                 i, got.ctl, got.stall, got.flush, want.ctl, want.stall, want.flush);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    stim_t tbl[8];
    tbl = '{ {I_REQ,   C_RUN_FRZ, 4'd0, 4'd0},
             {I_REQ,   C_MW_FRZ,  4'd1, 4'd0},
             {I_REQ,   C_MW_FRZ,  4'd2, 4'd0},
             {I_REQ,   C_MW_FRZ,  4'd3, 4'd0},
             {I_REQ,   C_ERR,     4'd4, 4'd0},
             {I_START, C_ERR,     4'd4, 4'd0},
             {I_NONE,  C_ERR,     4'd4, 4'd0},
             {I_ACK,   C_ERR,     4'd4, 4'd0} };
    restart();
    foreach (tbl[i]) begin
      apply(tbl[i].in);
      sb_q.push_back({tbl[i].ctl, tbl[i].stall, tbl[i].flush});
      @(negedge clk);
      got = dut_obs(); want = sb_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL timeout[%0d]: got ctl=%b stall=%0d flush=%0d, expected ctl=%b stall=%0d flush=%0d",
                 i, got.ctl, got.stall, got.flush, want.ctl, want.stall, want.flush);
      end
      @(posedge clk); #1;
    end
    // ERROR only leaves through reset, which acts without waiting for an edge
    apply(I_NONE);
    reset = 1'b1;
    sb_q.push_back({C_IDLE, 4'd0, 4'd0});
    #2;
    got = dut_obs(); want = sb_q.pop_front(); n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL timeout_reset: got ctl=%b stall=%0d flush=%0d, expected ctl=%b stall=%0d flush=%0d",
               got.ctl, got.stall, got.flush, want.ctl, want.stall, want.flush);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_async_reset();
    stim_t tbl[2];
    tbl = '{ {I_REQ, C_RUN_FRZ, 4'd0, 4'd0},
             {I_REQ, C_MW_FRZ,  4'd1, 4'd0} };
    restart();
    foreach (tbl[i]) begin
      apply(tbl[i].in);
      sb_q.push_back({tbl[i].ctl, tbl[i].stall, tbl[i].flush});
      @(negedge clk);
      got = dut_obs(); want = sb_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL async_reset[%0d]: got ctl=%b stall=%0d flush=%0d, expected ctl=%b stall=%0d flush=%0d",
                 i, got.ctl, got.stall, got.flush, want.ctl, want.stall, want.flush);
      end
      @(posedge clk); #1;
    end
    // Mid-stall reset: outputs must collapse before the next clock edge
    reset = 1'b1;
    sb_q.push_back({C_IDLE, 4'd0, 4'd0});
    #2;
    got = dut_obs(); want = sb_q.pop_front(); n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL async_reset_mid: got ctl=%b stall=%0d flush=%0d, expected ctl=%b stall=%0d flush=%0d",
               got.ctl, got.stall, got.flush, want.ctl, want.stall, want.flush);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    apply(I_NONE);
    sb_q.push_back({C_IDLE, 4'd0, 4'd0});
    @(negedge clk);
    got = dut_obs(); want = sb_q.pop_front(); n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL async_reset_after: got ctl=%b stall=%0d flush=%0d, expected ctl=%b stall=%0d flush=%0d",
               got.ctl, got.stall, got.flush, want.ctl, want.stall, want.flush);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    restart();
    for (int i = 0; i <= 20; i++) begin
      apply((i < 20) ? I_BUB : I_NONE);
      sb_q.push_back({(i < 20) ? C_RUN_BUB : C_RUN_ALL, (i < 15) ? 4'(i) : 4'd15, 4'd0});
      @(negedge clk);
      got = dut_obs(); want = sb_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL saturation[%0d]: got ctl=%b stall=%0d flush=%0d, expected ctl=%b stall=%0d flush=%0d",
                 i, got.ctl, got.stall, got.flush, want.ctl, want.stall, want.flush);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    apply(I_NONE);
    reset = 1'b1;
    test_reset();
    test_bubble();
    test_mem_wait();
    test_branch_priority();
    test_halt();
    test_back_to_back();
    test_timeout();
    test_async_reset();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
